multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control FSM for the 8-bit MIPS datapath. It sequences every instruction through byte-wise fetch, decode, execute, memory and writeback. It drives the per-byte `irwrite[3:0]` enables of the four 8-bit instruction-register `flopen` stages and the PC `flopen` enable (`pcen`). It sits directly upstream of those enable flops and of the datapath muxes and ALU decoder.

## Interface
Parameters: none; opcodes are fixed (see Operation).

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `op` in 6: opcode, `instr[31:26]`, from the IR flops.
- `zero` in 1: ALU zero flag.
- `memread` out 1: memory read strobe.
- `memwrite` out 1: memory write strobe.
- `alusrca` out 1: ALU A select; 0=PC, 1=register A.
- `alusrcb` out 2: ALU B select; 00=reg B, 01=const 1, 10=imm, 11=imm (branch offset).
- `aluop` out 2: to ALU decoder; 00=add, 01=sub, 10=funct field.
- `pcsource` out 2: PC next select; 00=ALU result, 01=ALUOut, 10=jump target.
- `iord` out 1: memory address select; 0=PC, 1=ALUOut.
- `memtoreg` out 1: register writeback select; 1=memory data.
- `regdst` out 1: destination register select; 1=rd, 0=rt.
- `regwrite` out 1: register file write enable.
- `irwrite` out 4: one-hot byte enable for IR byte 0..3.
- `pcen` out 1: PC flop enable.
- `state` out 4: current state encoding, for debug and verification.

## Operation
- Moore FSM with a 4-bit state register.
- All outputs decode from state only, except `pcen = pcwrite | (pcwritecond & zero)`.
- Encoding: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14. Code 15 is illegal and is treated as FETCH1.
- Outputs not listed in a state are 0.
  - FETCH1..FETCH4: memread=1, alusrcb=01, pcwrite=1, irwrite=0001/0010/0100/1000 respectively.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - LBRD: memread=1, iord=1.
  - LBWR: regwrite=1, memtoreg=1.
  - SBWR: memwrite=1, iord=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWR: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcwritecond=1, pcsource=01.
  - JEX: pcwrite=1, pcsource=10.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWR: regwrite=1.
- Transitions:
  - FETCH1→FETCH2→FETCH3→FETCH4→DECODE unconditionally.
  - DECODE dispatches on `op`: LB 100000→MEMADR; SB 101000→MEMADR; R-type 000000→RTYPEEX; BEQ 000100→BEQEX; J 000010→JEX; ADDI 001000→ADDIEX; any other op→FETCH1 (instruction ignored, no side effects).
  - MEMADR: op=LB→LBRD, op=SB→SBWR, otherwise→FETCH1.
  - LBRD→LBWR.
  - RTYPEEX→RTYPEWR.
  - ADDIEX→ADDIWR.
  - LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR→FETCH1.
  - Illegal state→FETCH1.
- Invariants:
  - At most one `irwrite` bit is set at any time.
  - `memread` and `memwrite` are never both 1.

## Timing
- Reset: if `reset`=1 at a rising edge, state←FETCH1.
- While `reset` is high, all outputs are forced to 0, including `pcen` and `irwrite`, so no flop updates. `state` still reports the register value.
- Reset asserted mid-instruction aborts it: no further writes, and the first cycle after deassertion is FETCH1.
- `op` is sampled only in DECODE and MEMADR. IR byte 3 is loaded at the end of FETCH4, so `op` is stable from DECODE onward.
- Latency in cycles, FETCH1 to next FETCH1: LB 8, SB 7, R-type 7, ADDI 7, BEQ 6, J 6, unknown op 5.
- `pcen` in BEQEX follows `zero` combinationally in the same cycle. The PC updates at the end of BEQEX only if zero=1.

## Test plan
- Reset: hold `reset`=1 for 3 cycles, release. Required: state=0 with all outputs 0 during reset; on the first cycle after release, irwrite=0001, pcen=1, memread=1.
- Fetch: run 4 cycles from FETCH1 with op=000000. Required: irwrite steps 0001,0010,0100,1000 and pcen=1 in each cycle; then DECODE with alusrcb=11; then RTYPEEX with aluop=10; then RTYPEWR with regdst=1, regwrite=1; then FETCH1.
- LB/SB: with op=100000, state passes 4,5,6,7 and back to 0, with iord=1 in LBRD and memtoreg=1, regwrite=1 in LBWR. With op=101000, state passes 4,5,8 and back to 0, with memwrite=1 only in SBWR.
- BEQ: in BEQEX with zero=0, pcen=0; with zero=1, pcen=1 and pcsource=01. Both cases return to FETCH1.
- J and unknown op: op=000010 gives JEX with pcen=1, pcsource=10. op=111111 goes DECODE→FETCH1 with regwrite, memwrite and pcen all 0 in DECODE.
- Mid-operation reset: assert `reset` in LBRD. Required: regwrite is never asserted, and state=0 on the next edge.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 8-bit MIPS datapath: byte-wise fetch, decode,
// execute, memory and writeback sequencing with Moore-decoded control outputs.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic [3:0] irwrite,
  output logic       pcen,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,  FETCH2  = 4'd1,  FETCH3 = 4'd2,  FETCH4 = 4'd3,
    DECODE  = 4'd4,  MEMADR  = 4'd5,  LBRD   = 4'd6,  LBWR   = 4'd7,
    SBWR    = 4'd8,  RTYPEEX = 4'd9,  RTYPEWR = 4'd10, BEQEX = 4'd11,
    JEX     = 4'd12, ADDIEX  = 4'd13, ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t r_state;
  state_t w_next;
  logic   w_pcwrite;
  logic   w_pcwritecond;

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH1;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = FETCH1;
    case (r_state)
      FETCH1:  w_next = FETCH2;
      FETCH2:  w_next = FETCH3;
      FETCH3:  w_next = FETCH4;
      FETCH4:  w_next = DECODE;
      DECODE: begin
        case (op)
          OP_LB, OP_SB: w_next = MEMADR;
          OP_RTYP:      w_next = RTYPEEX;
          OP_BEQ:       w_next = BEQEX;
          OP_J:         w_next = JEX;
          OP_ADDI:      w_next = ADDIEX;
          default:      w_next = FETCH1;
        endcase
      end
      MEMADR: begin
        if      (op == OP_LB) w_next = LBRD;
        else if (op == OP_SB) w_next = SBWR;
        else                  w_next = FETCH1;
      end
      LBRD:    w_next = LBWR;
      RTYPEEX: w_next = RTYPEWR;
      ADDIEX:  w_next = ADDIWR;
      default: w_next = FETCH1;
    endcase
  end

  // Outputs are held low during reset so no downstream flop can update.
  always_comb begin
    memread       = 1'b0;
    memwrite      = 1'b0;
    alusrca       = 1'b0;
    alusrcb       = 2'b00;
    aluop         = 2'b00;
    pcsource      = 2'b00;
    iord          = 1'b0;
    memtoreg      = 1'b0;
    regdst        = 1'b0;
    regwrite      = 1'b0;
    irwrite       = 4'b0000;
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    if (!reset) begin
      case (r_state)
        FETCH1, FETCH2, FETCH3, FETCH4: begin
          memread   = 1'b1;
          alusrcb   = 2'b01;
          w_pcwrite = 1'b1;
          irwrite   = 4'b0001 << r_state[1:0];
        end
        DECODE:  alusrcb = 2'b11;
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        LBRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        LBWR: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        SBWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        RTYPEWR: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        BEQEX: begin
          alusrca       = 1'b1;
          aluop         = 2'b01;
          w_pcwritecond = 1'b1;
          pcsource      = 2'b01;
        end
        JEX: begin
          w_pcwrite = 1'b1;
          pcsource  = 2'b10;
        end
        ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        ADDIWR:  regwrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign pcen  = w_pcwrite | (w_pcwritecond & zero);
  assign state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction state paths derived from
// the opcode, with random opcodes, random zero flag and random mid-instruction resets.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic [3:0] irwrite;
    logic       pcen;
  } exp_t;

  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] irwrite, state;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsource(pcsource), .iord(iord), .memtoreg(memtoreg),
    .regdst(regdst), .regwrite(regwrite), .irwrite(irwrite), .pcen(pcen),
    .state(state)
  );

  // Expected control word for a state, straight from the per-state output table.
  function automatic exp_t model(input logic [3:0] st, input logic z, input logic rst);
    exp_t e;
    logic pw, pwc;
    e = '0;
    e.st = st;
    pw = 1'b0;
    pwc = 1'b0;
    if (!rst) begin
      case (st)
        4'd0, 4'd1, 4'd2, 4'd3: begin
          e.memread = 1'b1; e.alusrcb = 2'b01; pw = 1'b1;
          e.irwrite = 4'b0001 << st;
        end
        4'd4:  e.alusrcb = 2'b11;
        4'd5:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
        4'd6:  begin e.memread = 1'b1; e.iord = 1'b1; end
        4'd7:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
        4'd8:  begin e.memwrite = 1'b1; e.iord = 1'b1; end
        4'd9:  begin e.alusrca = 1'b1; e.aluop = 2'b10; end
        4'd10: begin e.regdst = 1'b1; e.regwrite = 1'b1; end
        4'd11: begin e.alusrca = 1'b1; e.aluop = 2'b01; pwc = 1'b1; e.pcsource = 2'b01; end
        4'd12: begin pw = 1'b1; e.pcsource = 2'b10; end
        4'd13: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
        4'd14: e.regwrite = 1'b1;
        default: ;
      endcase
    end
    e.pcen = pw | (pwc & z);
    return e;
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return (o == OP_LB) || (o == OP_SB) || (o == OP_RTYP) ||
           (o == OP_BEQ) || (o == OP_J) || (o == OP_ADDI);
  endfunction

  // One instruction: fetch/decode, then the op-specific tail. Opcode bits are
  // garbage during fetch since the IR is still filling. abort_at<0 means no reset.
  task automatic run_instr(input logic [5:0] o, input int abort_at, input int zmode);
    int path[8];
    int len;
    logic rv, zv;
    logic [5:0] ov;
    path = '{0, 1, 2, 3, 4, 0, 0, 0};
    len = 5;
    case (o)
      OP_LB:   begin path[5] = 5; path[6] = 6; path[7] = 7; len = 8; end
      OP_SB:   begin path[5] = 5; path[6] = 8; len = 7; end
      OP_RTYP: begin path[5] = 9; path[6] = 10; len = 7; end
      OP_ADDI: begin path[5] = 13; path[6] = 14; len = 7; end
      OP_BEQ:  begin path[5] = 11; len = 6; end
      OP_J:    begin path[5] = 12; len = 6; end
      default: len = 5;
    endcase
    for (int i = 0; i < len; i++) begin
      rv = (i == abort_at);
      zv = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      ov = (i < 4) ? 6'($urandom) : o;
      @(posedge clk);
      #1;
      reset = rv;
      op    = ov;
      zero  = zv;
      q.push_back(model(4'(path[i]), zv, rv));
      if (rv) break;
    end
  endtask

  task automatic driver();
    logic [5:0] o;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      zero  = 1'($urandom_range(0, 1));
      q.push_back(model(4'd0, zero, 1'b1));
    end
    run_instr(OP_RTYP, -1, 2);
    run_instr(OP_LB,   -1, 2);
    run_instr(OP_SB,   -1, 2);
    run_instr(OP_BEQ,  -1, 0);
    run_instr(OP_BEQ,  -1, 1);
    run_instr(OP_J,    -1, 2);
    run_instr(6'b111111, -1, 1);
    run_instr(OP_ADDI, -1, 2);
    run_instr(OP_LB,    6, 2);
    run_instr(OP_RTYP, -1, 2);
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: o = OP_LB;
        1: o = OP_SB;
        2: o = OP_RTYP;
        3: o = OP_BEQ;
        4: o = OP_J;
        5: o = OP_ADDI;
        default: begin
          o = 6'($urandom);
          while (is_legal(o)) o = 6'($urandom);
        end
      endcase
      run_instr(o, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1, 2);
    end
    run_instr(OP_RTYP, -1, 2);
    done = 1'b1;
  endtask

  task automatic monitor();
    exp_t e, a;
    int cyc;
    cyc = 0;
    while (!(done && q.size() == 0)) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        n_tests++;
        n_fail++;
        $display("FAIL timeout: %0d cycles elapsed, required completion within 20000", cyc);
        break;
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        a.st = state;       a.memread = memread;   a.memwrite = memwrite;
        a.alusrca = alusrca; a.alusrcb = alusrcb;  a.aluop = aluop;
        a.pcsource = pcsource; a.iord = iord;      a.memtoreg = memtoreg;
        a.regdst = regdst;  a.regwrite = regwrite; a.irwrite = irwrite;
        a.pcen = pcen;
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL ctrl cycle %0d: got st=%0d word=%h, required st=%0d word=%h",
                   cyc, a.st, a, e.st, e);
        end
        n_tests++;
        if ($countones(irwrite) > 1 || (memread && memwrite)) begin
          n_fail++;
          $display("FAIL invariant cycle %0d: irwrite=%b memread=%b memwrite=%b, required onehot0 and exclusive",
                   cyc, irwrite, memread, memwrite);
        end
      end
    end
  endtask

  initial begin
    fork
      driver();
      monitor();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
